// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative RV32M multiply/divide unit (radix-2, one bit/cycle)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int CONTROL_WIDTH  = 3,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [CONTROL_WIDTH-1:0]  op_i,
  input  logic [DATA_WIDTH-1:0]     a_i,
  input  logic [DATA_WIDTH-1:0]     b_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_i,
  input  logic                      flush_i,
  output logic                      stall_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [DATA_WIDTH-1:0]     result_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_o
);

  localparam int N  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FAST = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             count_q, count_d;
  logic [CONTROL_WIDTH-1:0]  op_q, op_d;
  logic                      neg_q, neg_d;
  logic                      sign_a_q, sign_a_d;
  logic [N-1:0]              opnd_q, opnd_d;
  logic [2*N-1:0]            acc_q, acc_d;
  logic [REG_ADDR_WIDTH-1:0] rd_cap_q, rd_cap_d;
  logic [REG_ADDR_WIDTH-1:0] rd_out_q, rd_out_d;
  logic [N-1:0]              result_q, result_d;

  // Operand decode for the incoming op (only meaningful in IDLE)
  logic         in_div, in_a_signed, in_b_signed, a_neg, b_neg;
  logic         div_zero, div_ovf;
  logic [N-1:0] a_mag, b_mag, fast_val;

  assign in_div      = op_i[2];
  assign in_a_signed = in_div ? ~op_i[0] : (op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10);
  assign in_b_signed = in_div ? ~op_i[0] : (op_i[1:0] == 2'b01);
  assign a_neg       = in_a_signed & a_i[N-1];
  assign b_neg       = in_b_signed & b_i[N-1];
  assign a_mag       = a_neg ? -a_i : a_i;
  assign b_mag       = b_neg ? -b_i : b_i;
  assign div_zero    = in_div & (b_i == '0);
  assign div_ovf     = in_div & ~op_i[0] & (a_i == MIN_NEG) & (b_i == '1);
  assign fast_val    = div_zero ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : MIN_NEG);

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}
  logic [N:0]     mul_sum, rem_sh, div_diff;
  logic [2*N-1:0] mul_next, div_next, step, prod_sel;
  logic [N-1:0]   quo_s, rem_s, calc_result;

  assign mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[N-1:1]};
  assign rem_sh   = acc_q[2*N-1:N-1];
  assign div_diff = rem_sh - {1'b0, opnd_q};
  assign div_next = div_diff[N] ? {rem_sh[N-1:0], acc_q[N-2:0], 1'b0}
                                : {div_diff[N-1:0], acc_q[N-2:0], 1'b1};
  assign step     = op_q[2] ? div_next : mul_next;

  assign prod_sel = neg_q ? -step : step;
  assign quo_s    = neg_q ? -step[N-1:0] : step[N-1:0];
  assign rem_s    = sign_a_q ? -step[2*N-1:N] : step[2*N-1:N];
  assign calc_result = op_q[2] ? (op_q[1] ? rem_s : quo_s)
                               : ((op_q[1:0] == 2'b00) ? prod_sel[N-1:0] : prod_sel[2*N-1:N]);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    neg_d    = neg_q;
    sign_a_d = sign_a_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    rd_cap_d = rd_cap_q;
    rd_out_d = rd_out_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          op_d     = op_i;
          rd_cap_d = rd_i;
          neg_d    = a_neg ^ b_neg;
          sign_a_d = a_neg;
          if (div_zero || div_ovf) begin
            state_d = FAST;
            acc_d   = {{N{1'b0}}, fast_val};
          end else begin
            state_d = CALC;
            count_d = CW'(N - 1);
            opnd_d  = in_div ? b_mag : a_mag;
            acc_d   = {{N{1'b0}}, (in_div ? a_mag : b_mag)};
          end
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d = step;
          if (count_q == '0) begin
            result_d = calc_result;
            rd_out_d = rd_cap_q;
            state_d  = DONE;
          end else begin
            count_d = count_q - CW'(1);
          end
        end
      end
      FAST: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          result_d = acc_q[N-1:0];
          rd_out_d = rd_cap_q;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rd_cap_q <= '0;
      rd_out_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      sign_a_q <= sign_a_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      rd_cap_q <= rd_cap_d;
      rd_out_q <= rd_out_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == CALC) || (state_q == FAST);
  assign stall_o  = ((state_q == IDLE) && start_i && !flush_i) || busy_o;
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;
  assign rd_o     = rd_out_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : directed vector table plus flush/reset/ignore sequences
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
  localparam int LN = 33;
  localparam int LF = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic [4:0]  rd_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  muldiv_unit #(.DATA_WIDTH(32), .CONTROL_WIDTH(3), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .rd_i(rd_i), .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o),
    .done_o(done_o), .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done_o === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at a negedge: issues one op and follows it to its done pulse.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat,
                        input string name);
    int k;
    bit seen, flags_ok;
    op_i = op; a_i = a; b_i = b; rd_i = rd; start_i = 1'b1;
    #1;
    flags_ok = (stall_o === 1'b1);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    a_i = $urandom; b_i = $urandom; op_i = 3'($urandom); rd_i = 5'($urandom);
    k = 0; seen = 0;
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      if (done_o === 1'b1) begin
        seen = 1;
        if (stall_o !== 1'b0 || busy_o !== 1'b0) flags_ok = 0;
      end else if (stall_o !== 1'b1 || busy_o !== 1'b1) begin
        flags_ok = 0;
      end
    end
    check({name, "/latency"}, 64'(k), 64'(lat));
    check({name, "/result"}, {32'h0, result_o}, {32'h0, exp});
    check({name, "/rd"}, {59'h0, rd_o}, {59'h0, rd});
    @(negedge clk);
    if (done_o !== 1'b0 || result_o !== exp) flags_ok = 0;
    check({name, "/stall_busy_done_shape"}, {63'h0, flags_ok}, 64'h1);
  endtask

  initial begin
    int d0, k;
    bit ok;

    vecs[0]  = '{MUL,    32'h00000007, 32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, LN};
    vecs[1]  = '{MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'h00000000, LN};
    vecs[2]  = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'hFFFFFFFF, LN};
    vecs[3]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'hFFFFFFFE, LN};
    vecs[4]  = '{MULH,   32'h80000000, 32'h80000000, 5'd2,  32'h40000000, LN};
    vecs[5]  = '{MUL,    32'h12345678, 32'h00000010, 5'd3,  32'h23456780, LN};
    vecs[6]  = '{MULHU,  32'h80000000, 32'h00000002, 5'd4,  32'h00000001, LN};
    vecs[7]  = '{DIV,    32'hFFFFFFF9, 32'h00000002, 5'd5,  32'hFFFFFFFD, LN};
    vecs[8]  = '{REM,    32'hFFFFFFF9, 32'h00000002, 5'd6,  32'hFFFFFFFF, LN};
    vecs[9]  = '{DIVU,   32'd100,      32'd7,        5'd7,  32'd14,       LN};
    vecs[10] = '{REMU,   32'd100,      32'd7,        5'd8,  32'd2,        LN};
    vecs[11] = '{DIV,    32'h00000007, 32'hFFFFFFFE, 5'd9,  32'hFFFFFFFD, LN};
    vecs[12] = '{REM,    32'h00000007, 32'hFFFFFFFE, 5'd11, 32'h00000001, LN};
    vecs[13] = '{DIVU,   32'hFFFFFFFF, 32'h00000001, 5'd12, 32'hFFFFFFFF, LN};
    vecs[14] = '{DIVU,   32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000, LN};
    vecs[15] = '{DIVU,   32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, LF};
    vecs[16] = '{REM,    32'd5,        32'd0,        5'd15, 32'd5,        LF};
    vecs[17] = '{DIV,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, LF};
    vecs[18] = '{REM,    32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h00000000, LF};
    vecs[19] = '{DIV,    32'hFFFFFFF9, 32'd0,        5'd18, 32'hFFFFFFFF, LF};
    vecs[20] = '{REMU,   32'hFFFFFFF9, 32'd0,        5'd19, 32'hFFFFFFF9, LF};

    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    op_i = '0; a_i = '0; b_i = '0; rd_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/stall", {63'h0, stall_o}, 64'h0);
    check("reset/busy", {63'h0, busy_o}, 64'h0);
    check("reset/done", {63'h0, done_o}, 64'h0);
    check("reset/result", {32'h0, result_o}, 64'h0);
    check("reset/rd", {59'h0, rd_o}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat,
             $sformatf("vec%0d", i));

    // Flush during CALC, then an immediate new op
    d0 = done_cnt;
    op_i = DIV; a_i = 32'd100; b_i = 32'd7; rd_i = 5'd6; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    ok = 1;
    repeat (10) begin
      @(negedge clk);
      if (done_o !== 1'b0 || busy_o !== 1'b1) ok = 0;
    end
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    check("flush/busy_before", {63'h0, ok}, 64'h1);
    check("flush/busy_after", {63'h0, busy_o}, 64'h0);
    check("flush/done_after", {63'h0, done_o}, 64'h0);
    run_op(DIVU, 32'd100, 32'd7, 5'd20, 32'd14, LN, "after_flush");
    check("flush/done_count", 64'(done_cnt - d0), 64'd1);

    // Start and flush in the same IDLE cycle: nothing captured
    op_i = MUL; a_i = 32'd3; b_i = 32'd3; rd_i = 5'd21; start_i = 1'b1; flush_i = 1'b1;
    #1 check("startflush/stall", {63'h0, stall_o}, 64'h0);
    @(posedge clk);
    #1 begin start_i = 1'b0; flush_i = 1'b0; end
    @(negedge clk);
    check("startflush/busy", {63'h0, busy_o}, 64'h0);
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    check("startflush/no_done", 64'(done_cnt - d0), 64'd0);
    check("startflush/rd_held", {59'h0, rd_o}, 64'd20);

    // start_i in CALC and in DONE is ignored
    d0 = done_cnt;
    op_i = MUL; a_i = 32'd7; b_i = 32'd3; rd_i = 5'd4; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (5) @(negedge clk);
    op_i = DIVU; a_i = 32'd100; b_i = 32'd7; rd_i = 5'd9; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    k = 5;
    while (done_o !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("ignore/latency", 64'(k), 64'(LN));
    check("ignore/result", {32'h0, result_o}, 64'd21);
    check("ignore/rd", {59'h0, rd_o}, 64'd4);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    @(negedge clk);
    check("ignore/busy_after_done", {63'h0, busy_o}, 64'h0);
    repeat (40) @(negedge clk);
    check("ignore/done_count", 64'(done_cnt - d0), 64'd1);

    // Reset in the middle of a multiply
    d0 = done_cnt;
    op_i = MUL; a_i = 32'd9; b_i = 32'd9; rd_i = 5'd3; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midreset/stall", {63'h0, stall_o}, 64'h0);
    check("midreset/busy", {63'h0, busy_o}, 64'h0);
    check("midreset/done", {63'h0, done_o}, 64'h0);
    check("midreset/result", {32'h0, result_o}, 64'h0);
    check("midreset/rd", {59'h0, rd_o}, 64'h0);
    repeat (40) @(negedge clk);
    check("midreset/no_done", 64'(done_cnt - d0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
